// File: rtl/ceda_hyst_stage.sv
// Canny hysteresis stage: classifies gradient magnitudes against two thresholds and
// propagates edge connectivity from the left pixel and the previous row.
module ceda_hyst_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] cfg_thr_lo,
  input  logic [DATA_WIDTH-1:0] cfg_thr_hi,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic [31:0]           stat_edge_count,
  output logic                  stat_frame_done,
  output logic                  stat_line_err
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [DATA_WIDTH-1:0] thr_lo_reg, thr_hi_reg;
  logic [1:0]            mode_reg;
  logic [XW-1:0]         x_reg;
  logic [YW-1:0]         y_reg;
  logic                  left_final_reg;
  logic                  up_left_reg;
  logic                  m_last_row_reg;
  logic                  line_buf [IMG_WIDTH];

  logic                  accept;
  logic [DATA_WIDTH-1:0] thr_lo_eff, thr_hi_eff, lo_min;
  logic [1:0]            mode_eff;
  logic [XW-1:0]         x_cur, x_right;
  logic [YW-1:0]         y_cur;
  logic                  has_left, has_up, has_right;
  logic                  is_strong, is_weak, final_px, count_px;
  logic                  up_mid, up_right;
  logic                  eol, err_cond;
  logic [7:0]            px_out;

  assign s_tready = !m_tvalid || m_tready;
  assign accept   = s_tvalid && s_tready;

  // A start-of-frame beat already uses the new configuration and position.
  assign thr_lo_eff = s_tuser ? cfg_thr_lo : thr_lo_reg;
  assign thr_hi_eff = s_tuser ? cfg_thr_hi : thr_hi_reg;
  assign mode_eff   = s_tuser ? cfg_mode   : mode_reg;
  assign x_cur      = s_tuser ? '0 : x_reg;
  assign y_cur      = s_tuser ? '0 : y_reg;
  assign lo_min     = (thr_lo_eff < thr_hi_eff) ? thr_lo_eff : thr_hi_eff;

  assign is_strong = (s_tdata >= thr_hi_eff);
  assign is_weak   = !is_strong && (s_tdata >= lo_min);

  assign has_left  = (x_cur != '0);
  assign has_up    = (y_cur != '0);
  assign has_right = (x_cur != X_LAST);
  assign x_right   = has_right ? x_cur + 1'b1 : x_cur;

  // Buffer contents are never trusted outside the image, so masks gate every read.
  assign up_mid   = has_up && line_buf[x_cur];
  assign up_right = has_up && has_right && line_buf[x_right];
  assign final_px = is_strong ||
                    (is_weak && ((has_left && (left_final_reg || (has_up && up_left_reg)))
                                 || up_mid || up_right));
  assign count_px = (mode_eff != 2'd2) && final_px;

  always_comb begin
    px_out = 8'd0;
    case (mode_eff)
      2'd1:    px_out = final_px ? 8'd255 : (is_weak ? 8'd128 : 8'd0);
      2'd2:    px_out = s_tdata[DATA_WIDTH-1 -: 8];
      default: px_out = final_px ? 8'd255 : 8'd0;
    endcase
  end

  assign eol      = s_tlast || (x_cur == X_LAST);
  assign err_cond = s_tlast != (x_cur == X_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid        <= 1'b0;
      m_tdata         <= 8'd0;
      m_tlast         <= 1'b0;
      m_tuser         <= 1'b0;
      m_last_row_reg  <= 1'b0;
      stat_edge_count <= 32'd0;
      stat_frame_done <= 1'b0;
      stat_line_err   <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      left_final_reg  <= 1'b0;
      up_left_reg     <= 1'b0;
      thr_lo_reg      <= '1;
      thr_hi_reg      <= '1;
      mode_reg        <= 2'd0;
    end else begin
      stat_frame_done <= m_tvalid && m_tready && m_tlast && m_last_row_reg;
      if (accept) begin
        m_tvalid       <= 1'b1;
        m_tdata        <= px_out;
        m_tlast        <= s_tlast;
        m_tuser        <= s_tuser;
        m_last_row_reg <= (y_cur == Y_LAST);
        if (s_tuser) begin
          thr_lo_reg <= cfg_thr_lo;
          thr_hi_reg <= cfg_thr_hi;
          mode_reg   <= cfg_mode;
        end
        if (eol) begin
          x_reg <= '0;
          y_reg <= (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
        end else begin
          x_reg <= x_cur + 1'b1;
          y_reg <= y_cur;
        end
        left_final_reg <= final_px;
        // Old value above the current column becomes the up-left neighbour next beat.
        up_left_reg    <= line_buf[x_cur];
        stat_line_err  <= (stat_line_err && !s_tuser) || err_cond;
        if (s_tuser)
          stat_edge_count <= {31'd0, count_px};
        else if (count_px && (stat_edge_count != 32'hFFFF_FFFF))
          stat_edge_count <= stat_edge_count + 32'd1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      line_buf[x_cur] <= final_px;
  end

endmodule

// File: tb/tb_ceda_hyst_stage.sv
// Directed bench for ceda_hyst_stage on a 4x3 image with hand-computed expected pixels.
module tb_ceda_hyst_stage;
  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg_thr_lo = 8'd50, cfg_thr_hi = 8'd100;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] s_tdata = 8'd0;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tuser;
  logic       m_tready = 1'b1;
  logic [31:0] stat_edge_count;
  logic       stat_frame_done, stat_line_err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] out_q[$];

  ceda_hyst_stage #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_thr_lo(cfg_thr_lo), .cfg_thr_hi(cfg_thr_hi), .cfg_mode(cfg_mode),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .stat_edge_count(stat_edge_count), .stat_frame_done(stat_frame_done),
    .stat_line_err(stat_line_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Records every output transfer that the next rising edge will complete.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && m_tvalid && m_tready) out_q.push_back(m_tdata);
    if (stat_frame_done) done_cnt++;
  end

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
    int n;
    n = 0;
    s_tdata = d; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_tready) check_val("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] px[12], input logic [7:0] ex[12],
                           input int n, input logic [11:0] lmask, input int stall_at,
                           input int first_cnt, input int end_cnt, input logic end_err,
                           input int done_inc);
    int done_before;
    done_before = done_cnt;
    out_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        m_tready = 1'b0;
        s_tdata = px[i]; s_tlast = lmask[i]; s_tuser = 1'b0; s_tvalid = 1'b1;
        #2;
        for (int k = 0; k < 5; k++) begin
          check_val({tag, "_stall_s_tready"}, {31'd0, s_tready}, 32'd0);
          check_val({tag, "_stall_m_tdata"}, {24'd0, m_tdata}, {24'd0, ex[i-1]});
          @(negedge clk);
          #2;
        end
        m_tready = 1'b1;
      end
      send_beat(px[i], lmask[i], i == 0);
      if (i == 0) check_val({tag, "_cnt_after_sof"}, stat_edge_count, first_cnt);
    end
    repeat (3) @(negedge clk);
    check_val({tag, "_out_count"}, out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++)
      check_val($sformatf("%s_px%0d", tag, i), {24'd0, out_q[i]}, {24'd0, ex[i]});
    check_val({tag, "_edge_count"}, stat_edge_count, end_cnt);
    check_val({tag, "_line_err"}, {31'd0, stat_line_err}, {31'd0, end_err});
    check_val({tag, "_frame_done"}, done_cnt - done_before, done_inc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] px[12];
    logic [7:0] ex[12];

    repeat (2) @(negedge clk);
    check_val("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_val("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
    check_val("rst_edge_count", stat_edge_count, 32'd0);
    check_val("rst_line_err", {31'd0, stat_line_err}, 32'd0);
    check_val("rst_frame_done", {31'd0, stat_frame_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_s_tready", {31'd0, s_tready}, 32'd1);

    // Binary mode, 7 edge pixels in the frame.
    px = '{120, 60, 60, 10,  60, 10, 10, 60,  10, 10, 70, 200};
    ex = '{255, 255, 255, 0, 255, 0, 0, 255,  0, 0, 255, 255};
    run_frame("m0", px, ex, 12, 12'h888, -1, 1, 7, 1'b0, 1);

    // Same frame tri-level: no weak-only pixels, count restarts at 1.
    cfg_mode = 2'd1;
    run_frame("m1", px, ex, 12, 12'h888, -1, 1, 7, 1'b0, 1);

    // Isolated weak pixel in row 0 gives 128.
    px = '{10, 70, 10, 10,  10, 10, 10, 10,  10, 10, 10, 10};
    ex = '{0, 128, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    run_frame("iso", px, ex, 12, 12'h888, -1, 0, 0, 1'b0, 1);

    // lo above hi: weak band is empty.
    cfg_thr_lo = 8'd150;
    px = '{120, 90, 100, 99,  99, 99, 99, 99,  99, 99, 99, 99};
    ex = '{255, 0, 255, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    run_frame("lohi", px, ex, 12, 12'h888, -1, 1, 2, 1'b0, 1);

    // Bypass: data unmodified and never counted.
    cfg_thr_lo = 8'd50; cfg_mode = 2'd2;
    px = '{255, 7, 128, 0,  60, 60, 60, 60,  1, 2, 3, 255};
    run_frame("byp", px, px, 12, 12'h888, -1, 0, 0, 1'b0, 1);

    // Short first line (tlast at x=2); row 1 must start at x=0, y=1.
    cfg_mode = 2'd0;
    px = '{10, 10, 120,  60, 60, 10, 10,  0, 0, 0, 0, 0};
    ex = '{0, 0, 255,  0, 255, 0, 0,  0, 0, 0, 0, 0};
    run_frame("lerr", px, ex, 7, 12'h044, -1, 0, 2, 1'b1, 0);

    // Stall mid row 1; output identical to the no-stall run, error cleared by sof.
    px = '{120, 60, 60, 10,  60, 10, 10, 60,  10, 10, 70, 200};
    ex = '{255, 255, 255, 0, 255, 0, 0, 255,  0, 0, 255, 255};
    run_frame("stall", px, ex, 12, 12'h888, 6, 1, 7, 1'b0, 1);

    // Asynchronous reset mid-frame drops the in-flight beat.
    send_beat(8'd120, 1'b0, 1'b1);
    send_beat(8'd60, 1'b0, 1'b0);
    check_val("pre_rst_m_tvalid", {31'd0, m_tvalid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_val("async_rst_edge_count", stat_edge_count, 32'd0);
    check_val("async_rst_m_tdata", {24'd0, m_tdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_s_tready", {31'd0, s_tready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ceda_hyst_stage.md
CEDA_HYST_STAGE -- requirements
Module: ceda_hyst_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning input gradient-magnitude width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 1920, meaning pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 1080, meaning lines per frame.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports cfg_thr_lo and cfg_thr_hi, input, DATA_WIDTH each, meaning the low and high thresholds.
REQ-007 SHALL have port cfg_mode, input, 2, meaning output mode: 0 binary, 1 tri-level, 2 bypass, 3 reserved (behaves as 0).
REQ-008 SHALL have ports s_tdata (input, DATA_WIDTH), s_tvalid (input, 1), s_tready (output, 1), s_tlast (input, 1, end of line) and s_tuser (input, 1, start of frame), meaning the AXI-Stream slave.
REQ-009 SHALL have ports m_tdata (output, 8), m_tvalid (output, 1), m_tready (input, 1), m_tlast (output, 1) and m_tuser (output, 1), meaning the AXI-Stream master.
REQ-010 SHALL have port stat_edge_count, output, 32, meaning the count of 255-valued pixels output in the current or last frame.
REQ-011 SHALL have port stat_frame_done, output, 1, meaning a one-cycle pulse at frame end.
REQ-012 SHALL have port stat_line_err, output, 1, meaning a sticky line-length error flag.

Function
REQ-013 SHALL transfer a beat only when tvalid and tready are both high on a rising clk edge.
REQ-014 SHALL drive s_tready = !m_tvalid || m_tready, with a single output register, a latency of 1 cycle from accept to m_tvalid, no bubbles at full throughput, and m_tdata/m_tlast/m_tuser held stable while m_tvalid && !m_tready.
REQ-015 SHALL on an accepted beat with s_tuser=1 latch cfg_thr_lo, cfg_thr_hi and cfg_mode for the whole frame, and set column x=0 and row y=0 for that beat.
REQ-016 SHALL classify each pixel p using the latched values: strong if p >= thr_hi; weak if lo_eff <= p < thr_hi, where lo_eff = min(thr_lo, thr_hi); none otherwise.
REQ-017 SHALL compute final(x,y) = strong, or weak AND any of final(x-1,y), final(x-1,y-1), final(x,y-1), final(x+1,y-1).
REQ-018 SHALL treat every out-of-image neighbour as 0, including row y=0, column 0 left neighbours and column IMG_WIDTH-1 right neighbours, regardless of buffer contents.
REQ-019 SHALL store final() for the previous row in an IMG_WIDTH x 1-bit line buffer that is written only on an accepted beat.
REQ-020 SHALL produce m_tdata per mode: in mode 0, 255 if final else 0; in mode 1, 255 if final, 128 if weak and not final, else 0; in mode 2, s_tdata[DATA_WIDTH-1 -: 8] unmodified (the line buffer is still updated).
REQ-021 SHALL delay m_tlast and m_tuser with their pixel, passing s_tlast and s_tuser through unchanged.
REQ-022 SHALL advance x on each accepted beat, and on s_tlast or x==IMG_WIDTH-1 set x=0 and y=y+1; y SHALL wrap to 0 after IMG_HEIGHT-1.
REQ-023 SHALL set stat_line_err when s_tlast is accepted with x != IMG_WIDTH-1, or when x==IMG_WIDTH-1 is accepted without s_tlast; the flag SHALL clear only on an accepted s_tuser beat.
REQ-024 SHALL clear stat_edge_count to 0 on an accepted s_tuser beat, or to 1 if that first pixel outputs 255.
REQ-025 SHALL increment stat_edge_count for each accepted input beat whose output value is 255 in modes 0, 1 and 3, never increment it in mode 2, and saturate it at 0xFFFFFFFF.
REQ-026 SHALL pulse stat_frame_done for exactly one cycle when the output beat of row IMG_HEIGHT-1 with m_tlast=1 transfers, with stat_edge_count holding its value until the next s_tuser.
REQ-027 SHALL, when s_tuser arrives mid-frame, restart at x=0 and y=0 and treat row 0 per REQ-018, without flushing the output register.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously force m_tvalid, m_tdata, m_tlast, m_tuser, stat_edge_count, stat_frame_done, stat_line_err, x and y to 0.
REQ-029 SHALL reset the latched thresholds to all-ones and the latched mode to 0; s_tready SHALL read 1 after reset.
REQ-030 SHALL leave the line buffer contents unreset, with correctness guaranteed by REQ-018.
REQ-031 SHALL, on reset asserted mid-frame, drop the in-flight beat, and SHALL require an s_tuser beat before normal operation resumes.

Verification
REQ-032 SHALL cover, with W=4, H=3, lo=50, hi=100 and mode 0, the row-0 input {120,60,60,10}: output {255,255,255,0}, and row 1 {60,10,10,60} gives {255,0,0,255}.
REQ-033 SHALL cover the same frame in mode 1: row 1 yields {255,0,0,255}, and an isolated weak 70 with no final neighbours yields 128.
REQ-034 SHALL cover lo=150 with hi=100: 120 is classified as strong, 90 as none, and no weak pixel ever appears.
REQ-035 SHALL cover holding m_tready=0 for 5 cycles mid-line: s_tready stays 0, m_tdata stays stable, and the output sequence is identical to the no-stall run.
REQ-036 SHALL cover s_tlast at x=2 with W=4: stat_line_err goes to 1, the next pixel is at x=0 of the next row, and the flag clears on the next s_tuser.
REQ-037 SHALL cover a full 4x3 frame whose output has 7 pixels of 255: stat_frame_done pulses once on the last beat, stat_edge_count=7, and it resets to 0 or 1 on the next s_tuser.
